// File: rtl/uart_protocol_writer_pkg.sv
// uart_protocol_writer_pkg: datamem geometry, protocol window constants and rx FSM state type
package uart_protocol_writer_pkg;
  localparam int DATAMEM_BITS = 14;
  localparam int DATAMEM_WIDTH = 32;
  localparam logic [DATAMEM_BITS-1:0] PROTOCOLMEM_BASE = 14'h2000;
  localparam int PROTOCOLMEM_WORDS = 16;
  localparam int PTR_BITS = $clog2(PROTOCOLMEM_WORDS * 4);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, BREAK} rx_state_t;
  function automatic logic [3:0] lane_mask(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronizer + 8N1 bit FSM (con_clk, rst, uart_rx -> rx_byte, byte_ok/byte_err pulses at the stop-bit sample)
module uart_rx_core
  import uart_protocol_writer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       con_clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       byte_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic rx_m, rx_s;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic stop_tick;
  assign stop_tick = state == STOP && cnt == FULL;
  assign byte_ok = stop_tick && rx_s;
  assign byte_err = stop_tick && !rx_s;
  always_ff @(posedge con_clk)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          state <= rx_s ? IDLE : DATA;
        end
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          rx_byte <= {rx_s, rx_byte[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          state <= rx_s ? WRITE : BREAK;
        end
        WRITE: state <= IDLE;
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_protocol_writer.sv
// uart_protocol_writer: UART bytes -> single-lane writes into the PROTOCOLMEM window (con_write/con_addr/con_in/rx_valid, byte_ptr, wrapped, frame_err)
module uart_protocol_writer
  import uart_protocol_writer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     con_clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  input  logic                     ptr_clr,
  output logic [3:0]               con_write,
  output logic [DATAMEM_BITS-1:0]  con_addr,
  output logic [DATAMEM_WIDTH-1:0] con_in,
  output logic                     rx_valid,
  output logic [PTR_BITS-1:0]      byte_ptr,
  output logic                     wrapped,
  output logic                     frame_err
);
  logic [7:0] rx_byte;
  logic byte_ok, byte_err;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .con_clk (con_clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_byte (rx_byte),
    .byte_ok (byte_ok),
    .byte_err(byte_err)
  );
  always_ff @(posedge con_clk)
    if (rst) begin
      con_write <= '0;
      con_addr <= '0;
      con_in <= '0;
      rx_valid <= 1'b0;
      byte_ptr <= '0;
      wrapped <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      con_write <= byte_ok ? lane_mask(byte_ptr[1:0]) : 4'b0;
      rx_valid <= byte_ok;
      if (byte_ok) begin
        con_addr <= {PROTOCOLMEM_BASE[DATAMEM_BITS-1:PTR_BITS-2], byte_ptr[PTR_BITS-1:2]};
        con_in <= {4{rx_byte}};
      end
      if (ptr_clr) begin
        byte_ptr <= '0;
        wrapped <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (byte_ok) byte_ptr <= byte_ptr + 1'b1;
        if (byte_ok && &byte_ptr) wrapped <= 1'b1;
        if (byte_err) frame_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_protocol_writer.sv
// tb_uart_protocol_writer: randomized UART frames checked against a pointer/window reference model
module tb_uart_protocol_writer;
  localparam int CPB = 16;
  logic con_clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, ptr_clr = 1'b0;
  logic [3:0] con_write;
  logic [13:0] con_addr;
  logic [31:0] con_in;
  logic rx_valid, wrapped, frame_err;
  logic [5:0] byte_ptr;
  int n_vec = 0, n_err = 0;
  int m_ptr = 0, m_wrap = 0, m_ferr = 0;
  logic [50:0] got_q[$], exp_q[$];
  logic [31:0] mem[16];

  uart_protocol_writer #(.CLKS_PER_BIT(CPB)) dut (
    .con_clk  (con_clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .ptr_clr  (ptr_clr),
    .con_write(con_write),
    .con_addr (con_addr),
    .con_in   (con_in),
    .rx_valid (rx_valid),
    .byte_ptr (byte_ptr),
    .wrapped  (wrapped),
    .frame_err(frame_err)
  );

  always #5 con_clk = ~con_clk;

  always @(negedge con_clk)
    if (!rst && (rx_valid || con_write != 4'b0)) begin
      got_q.push_back({rx_valid, con_write, con_addr, con_in});
      for (int b = 0; b < 4; b++)
        if (con_write[b]) mem[con_addr[3:0]][31-8*b -: 8] = con_in[31-8*b -: 8];
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_wr(input logic [7:0] b);
    logic [3:0] lane;
    logic [13:0] addr;
    lane = 4'(1 << (m_ptr % 4));
    addr = 14'h2000 + 14'(m_ptr / 4);
    exp_q.push_back({1'b1, lane, addr, {4{b}}});
    m_ptr = (m_ptr + 1) % 64;
    if (m_ptr == 0) m_wrap = 1;
  endtask

  task automatic model_clr();
    m_ptr = 0;
    m_wrap = 0;
    m_ferr = 0;
  endtask

  task automatic drain();
    chk("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) chk("wr", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    chk("byte_ptr", 64'(byte_ptr), 64'(m_ptr));
    chk("wrapped", 64'(wrapped), 64'(m_wrap));
    chk("frame_err", 64'(frame_err), 64'(m_ferr));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge con_clk) uart_rx = 1'b0;
    repeat (CPB - 1) @(negedge con_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge con_clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge con_clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_wr(b);
    repeat ($urandom_range(2, 12)) @(negedge con_clk);
    drain();
  endtask

  task automatic send_bad(input logic [7:0] b);
    send_frame(b, 1'b0);
    uart_rx = 1'b0;
    repeat (100) @(negedge con_clk);
    uart_rx = 1'b1;
    m_ferr = 1;
    repeat (10) @(negedge con_clk);
    drain();
  endtask

  task automatic pulse_clr();
    @(negedge con_clk) ptr_clr = 1'b1;
    @(negedge con_clk) ptr_clr = 1'b0;
    model_clr();
    repeat (2) @(negedge con_clk);
    drain();
  endtask

  initial begin
    logic [7:0] b;
    int k;
    repeat (3) @(negedge con_clk);
    chk("reset_outs", 64'({con_write, con_addr, con_in, rx_valid, byte_ptr, wrapped, frame_err}), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge con_clk);
    send_good(8'hA5);
    pulse_clr();
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    send_good(8'h44);
    send_good(8'h55);
    chk("word0", 64'(mem[0]), 64'h11223344);
    @(negedge con_clk) uart_rx = 1'b0;
    repeat (8) @(negedge con_clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge con_clk);
    drain();
    send_good(8'($urandom));
    send_bad(8'($urandom));
    send_good(8'h7E);
    pulse_clr();
    for (int i = 0; i < 65; i++) send_good(8'($urandom));
    b = 8'($urandom);
    k = 0;
    fork
      send_frame(b, 1'b1);
      begin
        while (!rx_valid && k < 400) begin
          @(negedge con_clk);
          k++;
        end
        chk("clr_wait", 64'(k < 400), 64'(1));
        ptr_clr = 1'b1;
        @(negedge con_clk) ptr_clr = 1'b0;
      end
    join
    model_wr(b);
    model_clr();
    repeat (4) @(negedge con_clk);
    drain();
    send_good(8'($urandom));
    send_bad(8'($urandom));
    @(negedge con_clk) uart_rx = 1'b0;
    repeat (CPB - 1) @(negedge con_clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'($urandom);
      repeat (CPB) @(negedge con_clk);
    end
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge con_clk);
    chk("rst_mid", 64'({con_write, con_addr, con_in, rx_valid, byte_ptr, wrapped, frame_err}), 64'(0));
    rst = 1'b0;
    got_q.delete();
    model_clr();
    repeat (200) @(negedge con_clk);
    drain();
    send_good(8'($urandom));
    for (int i = 0; i < 6; i++) send_good(8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
